fft_data_output: RTL and testbench
==================================

// Module: fft_data_output
// PURPOSE
// Downstream capture stage of the AXI FFT: AXIS slave fed by the FFT core's result stream.
// Stores one frame of POINT_SIZE complex samples {IM,RE} into dual RAM banks.
// Exposes the frame to the register interface as a flat word-addressed read port.
// Reports frame completion and framing errors (early/missing tlast).
// PARAMETERS
// NFFT                3               log2 of FFT point count
// POINT_SIZE          2**NFFT         complex samples per frame (computed)
// N_ELEMENTS          POINT_SIZE*2    32-bit words per frame (computed)
// ELEMENTS_ADDR_SIZE  $clog2(N_ELEMENTS)  word address / count width (computed)
// PORTS
// clk            in   1     single clock, all logic rising-edge
// resetn         in   1     synchronous, active-low reset
// s_tvalid       in   1     AXIS slave valid
// s_tready       out  1     AXIS slave ready
// s_tlast        in   1     AXIS last beat of frame
// s_tdata        in   64    {IM[63:32], RE[31:0]}
// rAddr          in   EAS   word address: even = RE, odd = IM of sample rAddr>>1
// rEn            in   1     read strobe
// rData          out  32    read data, valid 1 cycle after rEn
// arm            in   1     single-cycle pulse: start capture of next frame
// capturing      out  1     high while frame capture in progress (RAM read-locked)
// done           out  1     sticky: frame captured; cleared by arm or reset
// err_short      out  1     sticky: tlast seen before sample POINT_SIZE-1
// err_long       out  1     sticky: sample POINT_SIZE-1 accepted without tlast
// sample_count   out  EAS   samples accepted in current/last frame (0..POINT_SIZE)
// BEHAVIOUR
// - Reset (resetn=0 at clk edge): state IDLE; s_tready=0, capturing=0, done=0, err_*=0,
//   sample_count=0, rData=0. RAM contents not cleared. Reset mid-capture aborts frame.
// - States: IDLE -> (arm) -> CAPTURE -> (frame end) -> DONE -> (arm) -> CAPTURE.
// - IDLE/DONE: s_tready=0 (core back-pressured); arm enters CAPTURE next cycle,
//   clearing done, err_short, err_long, sample_count in the same edge.
// - CAPTURE: s_tready=1 registered, asserted first cycle in CAPTURE; capturing=1.
//   Beat accepted when s_tvalid&&s_tready; sample written at index sample_count,
//   RE to RE bank, IM to IM bank; sample_count increments by 1 per accepted beat.
// - Frame end, evaluated on accepted beat with index i=sample_count:
//   tlast && i==POINT_SIZE-1 -> DONE, no error.
//   tlast && i<POINT_SIZE-1 -> DONE, err_short=1 (remaining RAM entries stale).
//   !tlast && i==POINT_SIZE-1 -> DONE, err_long=1; later beats not accepted.
//   s_tready drops combinationally-free: deasserted the cycle after the final beat;
//   no beat is accepted in DONE. done rises the cycle after the final beat.
// - arm while in CAPTURE is ignored. arm coincident with reset: reset wins.
// - Read port: rData registered; rEn at edge N -> rData valid after edge N+1 and held
//   until next rEn. While capturing=1, reads return 0. rAddr[0] selects bank.
// - sample_count saturates at POINT_SIZE; never wraps.
// - RAM: two ad_mem instances, DATA_WIDTH 32, ADDRESS_WIDTH EAS-1, reb gated by resetn.
// TESTING (NFFT=3, POINT_SIZE=8)
// - arm, 8 beats tdata={k+100,k}, tlast on k=7, tvalid always 1 -> done=1, err_*=0,
//   sample_count=8; read rAddr=0..15 gives k, k+100 alternating; reads 0 while capturing.
// - s_tvalid toggled 1010..., plus beats offered before arm -> no beat accepted while
//   IDLE (s_tready=0); frame captured intact, sample_count=8.
// - tlast on beat 4 -> done=1, err_short=1, sample_count=5, s_tready=0 afterwards.
// - 9 beats, no tlast -> 8 accepted, err_long=1, done=1, 9th beat held (s_tready=0).
// - resetn=0 after beat 3 -> all outputs 0 next cycle, state IDLE; re-arm, full frame ok.
// - arm pulse mid-capture ignored; arm in DONE clears done/err_* and recaptures.

Source files
------------

// File: rtl/fft_data_output.sv
// Capture stage: stores one FFT result frame from AXIS into RE/IM RAM banks, exposes it as a word read port.
// Latency: beat written on acceptance edge; rData valid after the second edge following rEn.
// Backpressure: s_tready high only while in CAPTURE; core is stalled in IDLE/DONE and after the last beat.

module ad_mem #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clka,
  input  logic                     wea,
  input  logic [ADDRESS_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0]    dina,
  input  logic                     clkb,
  input  logic                     reb,
  input  logic [ADDRESS_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0]    doutb
);

  logic [DATA_WIDTH-1:0] m [0:(2**ADDRESS_WIDTH)-1];

  always_ff @(posedge clka) begin
    if (wea) m[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    if (reb) doutb <= m[addrb];
  end

endmodule

module fft_data_output #(
  parameter  int NFFT               = 3,
  localparam int POINT_SIZE         = 2**NFFT,
  localparam int N_ELEMENTS         = POINT_SIZE*2,
  localparam int ELEMENTS_ADDR_SIZE = $clog2(N_ELEMENTS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          s_tlast,
  input  logic [63:0]                   s_tdata,
  input  logic [ELEMENTS_ADDR_SIZE-1:0] rAddr,
  input  logic                          rEn,
  output logic [31:0]                   rData,
  input  logic                          arm,
  output logic                          capturing,
  output logic                          done,
  output logic                          err_short,
  output logic                          err_long,
  output logic [ELEMENTS_ADDR_SIZE-1:0] sample_count
);

  localparam logic [ELEMENTS_ADDR_SIZE-1:0] LAST_IDX  = ELEMENTS_ADDR_SIZE'(POINT_SIZE-1);
  localparam logic [ELEMENTS_ADDR_SIZE-1:0] MAX_COUNT = ELEMENTS_ADDR_SIZE'(POINT_SIZE);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t state, state_nxt;

  logic        accept;
  logic        at_last_idx;
  logic        frame_end;
  logic        arm_go;
  logic        mem_reb;
  logic [31:0] re_dout;
  logic [31:0] im_dout;
  logic        rd_en_q;
  logic        rd_sel_q;
  logic        rd_lock_q;

  // s_tready is only ever high in CAPTURE, so acceptance implies CAPTURE
  assign accept      = s_tvalid && s_tready;
  assign at_last_idx = (sample_count == LAST_IDX);
  assign frame_end   = accept && (s_tlast || at_last_idx);
  assign arm_go      = arm && (state != CAPTURE);
  assign mem_reb     = rEn && resetn;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = CAPTURE;
      CAPTURE: if (frame_end) state_nxt = DONE;
      DONE:    if (arm) state_nxt = CAPTURE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      s_tready     <= 1'b0;
      capturing    <= 1'b0;
      done         <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      sample_count <= '0;
    end else begin
      state     <= state_nxt;
      s_tready  <= (state_nxt == CAPTURE);
      capturing <= (state_nxt == CAPTURE);
      done      <= (state_nxt == DONE);
      if (arm_go) begin
        err_short    <= 1'b0;
        err_long     <= 1'b0;
        sample_count <= '0;
      end else if (accept) begin
        if (sample_count != MAX_COUNT)
          sample_count <= sample_count + ELEMENTS_ADDR_SIZE'(1);
        if (s_tlast && !at_last_idx)
          err_short <= 1'b1;
        if (!s_tlast && at_last_idx)
          err_long <= 1'b1;
      end
    end
  end

  ad_mem #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (ELEMENTS_ADDR_SIZE-1)
  ) u_re_mem (
    .clka  (clk),
    .wea   (accept),
    .addra (sample_count[ELEMENTS_ADDR_SIZE-2:0]),
    .dina  (s_tdata[31:0]),
    .clkb  (clk),
    .reb   (mem_reb),
    .addrb (rAddr[ELEMENTS_ADDR_SIZE-1:1]),
    .doutb (re_dout)
  );

  ad_mem #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (ELEMENTS_ADDR_SIZE-1)
  ) u_im_mem (
    .clka  (clk),
    .wea   (accept),
    .addra (sample_count[ELEMENTS_ADDR_SIZE-2:0]),
    .dina  (s_tdata[63:32]),
    .clkb  (clk),
    .reb   (mem_reb),
    .addrb (rAddr[ELEMENTS_ADDR_SIZE-1:1]),
    .doutb (im_dout)
  );

  // Lock is sampled with the request so a read issued mid-capture returns 0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_en_q   <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_lock_q <= 1'b0;
      rData     <= '0;
    end else begin
      rd_en_q   <= rEn;
      rd_sel_q  <= rAddr[0];
      rd_lock_q <= capturing;
      if (rd_en_q)
        rData <= rd_lock_q ? 32'd0 : (rd_sel_q ? im_dout : re_dout);
    end
  end

endmodule

// File: tb/tb_fft_data_output.sv
// Directed bench for fft_data_output (NFFT=3): read-data scoreboard plus direct status checks.
module tb_fft_data_output;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [63:0] s_tdata;
  logic [3:0]  rAddr;
  logic        rEn;
  logic [31:0] rData;
  logic        arm;
  logic        capturing;
  logic        done;
  logic        err_short;
  logic        err_long;
  logic [3:0]  sample_count;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q [$];
  logic rd_p1 = 1'b0;
  logic rd_p2 = 1'b0;

  fft_data_output #(.NFFT(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .s_tdata      (s_tdata),
    .rAddr        (rAddr),
    .rEn          (rEn),
    .rData        (rData),
    .arm          (arm),
    .capturing    (capturing),
    .done         (done),
    .err_short    (err_short),
    .err_long     (err_long),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Read responses are due two edges after the request edge
  always @(posedge clk) begin
    rd_p2 <= rd_p1 && resetn;
    rd_p1 <= rEn && resetn;
  end

  always @(negedge clk) begin
    if (rd_p2) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL rdata_unexpected: got %0d with empty scoreboard", rData);
      end else begin
        chk("rdata", rData, exp_q.pop_front());
      end
    end
  end

  task automatic do_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic send_beat(input int re, input int im, input bit last, input int gap);
    bit acc;
    int n;
    s_tvalid = 1'b1;
    s_tlast  = last;
    s_tdata  = {32'(im), 32'(re)};
    n = 0;
    do begin
      acc = s_tready;
      @(negedge clk);
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("beat_accept_timeout", 32'(acc), 32'd1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rd(input int a, input int exp);
    rEn   = 1'b1;
    rAddr = 4'(a);
    exp_q.push_back(32'(exp));
    @(negedge clk);
    rEn = 1'b0;
  endtask

  task automatic read_frame(input int off_re, input int off_im);
    for (int a = 0; a < 16; a++)
      rd(a, (a % 2 == 1) ? (a / 2 + off_im) : (a / 2 + off_re));
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_status(input string tag, input bit e_done, input bit e_short,
                            input bit e_long, input int e_cnt);
    chk({tag, "_done"},      32'(done),         32'(e_done));
    chk({tag, "_err_short"}, 32'(err_short),    32'(e_short));
    chk({tag, "_err_long"},  32'(err_long),     32'(e_long));
    chk({tag, "_count"},     32'(sample_count), 32'(e_cnt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_tready"},  32'(s_tready),  32'd0);
    chk({tag, "_capturing"}, 32'(capturing), 32'd0);
    chk({tag, "_rdata"},     rData,          32'd0);
    chk_status(tag, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; arm = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; rEn = 1'b0; rAddr = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Full clean frame, plus a read while capturing
    do_arm();
    chk("t1_capturing", 32'(capturing), 32'd1);
    chk("t1_tready", 32'(s_tready), 32'd1);
    rd(0, 0);
    for (int k = 0; k < 8; k++) send_beat(k, k + 100, k == 7, 0);
    chk_status("t1", 1'b1, 1'b0, 1'b0, 8);
    chk("t1_tready_after", 32'(s_tready), 32'd0);
    chk("t1_capturing_after", 32'(capturing), 32'd0);
    read_frame(0, 100);

    // Beats offered while DONE are held off; then gapped valid
    s_tvalid = 1'b1; s_tdata = 64'd999;
    repeat (3) begin
      chk("t2_tready_prearm", 32'(s_tready), 32'd0);
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    chk("t2_count_prearm", 32'(sample_count), 32'd8);
    do_arm();
    for (int k = 0; k < 8; k++) send_beat(k + 10, k + 200, k == 7, 1);
    chk_status("t2", 1'b1, 1'b0, 1'b0, 8);
    read_frame(10, 200);

    // Early tlast on beat 4
    do_arm();
    chk("t3_done_cleared", 32'(done), 32'd0);
    for (int k = 0; k < 5; k++) send_beat(k + 20, k + 300, k == 4, 0);
    chk_status("t3", 1'b1, 1'b1, 1'b0, 5);
    @(negedge clk);
    chk("t3_tready", 32'(s_tready), 32'd0);
    rd(8, 24);
    rd(9, 304);
    rd(10, 15);
    repeat (3) @(negedge clk);

    // Missing tlast: ninth beat must be held
    do_arm();
    chk("t4_err_short_cleared", 32'(err_short), 32'd0);
    for (int k = 0; k < 8; k++) send_beat(k + 30, k + 400, 1'b0, 0);
    s_tvalid = 1'b1; s_tdata = {32'd999, 32'd999};
    repeat (3) begin
      chk("t4_tready_9th", 32'(s_tready), 32'd0);
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    chk_status("t4", 1'b1, 1'b0, 1'b1, 8);
    rd(14, 37);
    rd(15, 407);
    repeat (3) @(negedge clk);

    // Reset mid-capture, then a clean recapture
    do_arm();
    for (int k = 0; k < 4; k++) send_beat(k + 40, k + 500, 1'b0, 0);
    chk("t5_count_before_reset", 32'(sample_count), 32'd4);
    resetn = 1'b0;
    @(negedge clk);
    chk_all_zero("t5_reset");
    resetn = 1'b1;
    @(negedge clk);
    do_arm();
    for (int k = 0; k < 8; k++) send_beat(k + 50, k + 600, k == 7, 0);
    chk_status("t5", 1'b1, 1'b0, 1'b0, 8);
    read_frame(50, 600);

    // arm during CAPTURE ignored; arm in DONE restarts
    do_arm();
    for (int k = 0; k < 3; k++) send_beat(k + 60, k + 700, 1'b0, 0);
    do_arm();
    chk("t6_capturing_mid", 32'(capturing), 32'd1);
    chk("t6_count_mid", 32'(sample_count), 32'd3);
    for (int k = 3; k < 8; k++) send_beat(k + 60, k + 700, k == 7, 0);
    chk_status("t6", 1'b1, 1'b0, 1'b0, 8);
    do_arm();
    chk_status("t6_rearm", 1'b0, 1'b0, 1'b0, 0);
    chk("t6_rearm_capturing", 32'(capturing), 32'd1);
    for (int k = 0; k < 8; k++) send_beat(k + 70, k + 800, k == 7, 0);
    chk_status("t6_final", 1'b1, 1'b0, 1'b0, 8);
    read_frame(70, 800);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
